// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: arbitrates Ibex instr/data ports onto one 1-cycle-latency RAM.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflicts instead of instr priority with starvation counter.
module ibex_mem_arbiter #(
  parameter logic [31:0] MEM_START    = 32'h0000_0000,
  parameter int          MEM_SIZE     = 65536,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {NONE, INSTR, DATA} owner_e;
  localparam logic [31:0] MEM_MASK = 32'(MEM_SIZE - 1);
  owner_e owner_q, owner_d;
  logic err_q, err_d;
  logic data_wins, gi, gd, in_range;
  logic [31:0] addr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_q, rr_d;
`else
  localparam int WW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WW-1:0] LIM = WW'(STARVE_LIMIT);
  logic [WW-1:0] wait_q, wait_d;
`endif
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    data_wins = rr_q;
`else
    data_wins = (STARVE_LIMIT != 0) && (wait_q == LIM);
`endif
    gd = data_req_i && (!instr_req_i || data_wins);
    gi = instr_req_i && !gd;
    addr = gd ? data_addr_i : instr_addr_i;
    in_range = (addr & ~MEM_MASK) == MEM_START;
    mem_req_o = (gi || gd) && in_range;
    mem_we_o = gd && data_we_i;
    mem_be_o = gd ? data_be_i : gi ? 4'hf : 4'h0;
    mem_addr_o = (gi || gd) ? addr : 32'h0;
    mem_wdata_o = gd ? data_wdata_i : 32'h0;
    owner_d = gd ? DATA : gi ? INSTR : NONE;
    err_d = (gi || gd) && !in_range;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // rr_q names the port that wins the next conflict
    rr_d = (instr_req_i && data_req_i) ? ~rr_q : rr_q;
`else
    wait_d = (!data_req_i || gd) ? '0 : (wait_q == LIM) ? wait_q : wait_q + 1'b1;
`endif
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q <= NONE;
      err_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q <= 1'b0;
`else
      wait_q <= '0;
`endif
    end else begin
      owner_q <= owner_d;
      err_q <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q <= rr_d;
`else
      wait_q <= wait_d;
`endif
    end
  end
  assign instr_gnt_o = gi;
  assign data_gnt_o = gd;
  assign instr_rvalid_o = owner_q == INSTR;
  assign data_rvalid_o = owner_q == DATA;
  assign instr_err_o = instr_rvalid_o && err_q;
  assign data_err_o = data_rvalid_o && err_q;
  assign instr_rdata_o = (instr_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
  assign data_rdata_o = (data_rvalid_o && !err_q) ? mem_rdata_i : 32'h0;
  // response timing comes from owner_q, so the RAM must keep its fixed latency
  resp_valid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (owner_q != NONE && !err_q) |-> mem_rvalid_i)
    else $error("ibex_mem_arbiter: RAM did not return rvalid for in-range access");
endmodule
